// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus driver.
// Bit positions of the fields in the LSU LCD register word.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam int LCD_DATA_LSB = 0;
    localparam int LCD_RS_BIT   = 8;
    localparam int LCD_RW_BIT   = 9;
    localparam int LCD_GO_BIT   = 10;
    localparam int LCD_ON_BIT   = 31;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Load-and-count-down timer used to time each LCD bus phase.
// o_done is high while the count is zero.
module lcd_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// Turns the LSU LCD register word into HD44780 bus cycles.
// Define LCD_4BIT_EN for the 4-bit (two-nibble) panel interface.
import lcd_pkg::*;

module lcd_driver #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 25,
    parameter int HOLD_CYC  = 4,
    parameter int WAIT_CYC  = 2000,
    parameter int CNT_W     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_word,
    input  logic [7:0]  i_lcd_data,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_data_oe,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic [7:0]  o_rd_data
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  =
        (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic             go_q, on_q;
    logic [7:0]       data_q, rd_q;
    logic             rs_q, rw_q, oe_q, en_q, busy_q;
    logic             start, last_nib;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_value;
    logic [7:0]       rd_d;
    logic             unused_bits;

    assign start = i_lcd_word[LCD_GO_BIT] & ~go_q
                 & i_lcd_word[LCD_ON_BIT] & (state_q == IDLE);

`ifdef LCD_4BIT_EN
    logic phase_q;

    // Nibble phase: 0 = high nibble, 1 = low nibble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= 1'b0;
        end else if (start) begin
            phase_q <= 1'b0;
        end else if (state_q == HOLD && tmr_done) begin
            phase_q <= 1'b1;
        end
    end

    assign last_nib = phase_q;
    assign rd_d = phase_q ? {rd_q[7:4], i_lcd_data[7:4]}
                          : {i_lcd_data[7:4], rd_q[3:0]};
    assign o_lcd_data = phase_q ? {data_q[3:0], 4'b0000}
                                : {data_q[7:4], 4'b0000};
    assign unused_bits = ^{i_lcd_word[30:11], i_lcd_data[3:0]};
`else
    assign last_nib = 1'b1;
    assign rd_d = i_lcd_data;
    assign o_lcd_data = data_q;
    assign unused_bits = ^i_lcd_word[30:11];
`endif

    // Next-state and phase-timer reload selection.
    always_comb begin
        state_d   = state_q;
        tmr_value = '0;
        unique case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: if (tmr_done) state_d = PULSE;
            PULSE: if (tmr_done) state_d = HOLD;
            HOLD: begin
                if (tmr_done) begin
                    if (!last_nib) state_d = SETUP;
                    else if (WAIT_CYC == 0) state_d = IDLE;
                    else state_d = WAIT;
                end
            end
            WAIT:  if (tmr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        unique case (state_d)
            SETUP:   tmr_value = SETUP_LD;
            PULSE:   tmr_value = PULSE_LD;
            HOLD:    tmr_value = HOLD_LD;
            WAIT:    tmr_value = WAIT_LD;
            default: tmr_value = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    lcd_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_done  (tmr_done)
    );

    // State, latched bus fields, registered strobes and read capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            on_q    <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= i_lcd_word[LCD_GO_BIT];
            on_q    <= i_lcd_word[LCD_ON_BIT];
            en_q    <= (state_d == PULSE);
            busy_q  <= (state_d != IDLE);
            if (start) begin
                data_q <= i_lcd_word[LCD_DATA_LSB +: 8];
                rs_q   <= i_lcd_word[LCD_RS_BIT];
                rw_q   <= i_lcd_word[LCD_RW_BIT];
                oe_q   <= ~i_lcd_word[LCD_RW_BIT];
            end else if (state_d == WAIT || state_d == IDLE) begin
                oe_q   <= 1'b0;
            end
            if (state_q == PULSE && tmr_done && rw_q) begin
                rd_q <= rd_d;
            end
        end
    end

    assign o_lcd_data_oe = oe_q;
    assign o_lcd_rs      = rs_q;
    assign o_lcd_rw      = rw_q;
    assign o_lcd_en      = en_q;
    assign o_lcd_on      = on_q;
    assign o_busy        = busy_q;
    assign o_rd_data     = rd_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Scoreboard bench for lcd_driver: stimulus queues expected transactions,
// a monitor measures each bus transaction and compares at busy fall.
module tb_lcd_driver;

    localparam int SETUP = 4;
    localparam int PULSE = 25;
    localparam int HOLD  = 4;
    localparam int WAITC = 2000;
`ifdef LCD_4BIT_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif
    localparam int BUSY_LEN = NPH * (SETUP + PULSE + HOLD) + WAITC;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        logic       rw;
        logic       oe;
        logic [7:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout, rd;
    logic        oe, rs, rw, en, on, busy;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lcd_driver dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_lcd_word    (word),
        .i_lcd_data    (din),
        .o_lcd_data    (dout),
        .o_lcd_data_oe (oe),
        .o_lcd_rs      (rs),
        .o_lcd_rw      (rw),
        .o_lcd_en      (en),
        .o_lcd_on      (on),
        .o_busy        (busy),
        .o_rd_data     (rd)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: measures one transaction from busy rise to busy fall.
    bit         act = 0;
    bit         en_prev = 0;
    int         bcnt, pcnt, dly, elen;
    int         ntxn = 0;
    logic [7:0] seen;
    logic       rs_s, rw_s, oe_s;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            act = 0;
            en_prev = 0;
        end else begin
            if (busy && !act) begin
                act = 1; bcnt = 0; pcnt = 0; dly = 0; elen = 0; seen = '0;
            end
            if (act) begin
                if (busy) bcnt++;
                if (en && !en_prev) begin
                    pcnt++;
                    elen = 0;
                    if (pcnt == 1) begin
                        dly = bcnt; rs_s = rs; rw_s = rw; oe_s = oe;
                    end
`ifdef LCD_4BIT_EN
                    seen = {seen[3:0], dout[7:4]};
`else
                    seen = dout;
`endif
                end
                if (en) elen++;
                else if (en_prev) check("en_len", elen, PULSE);
                if (!busy) begin
                    ntxn++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_txn actual=1 required=0");
                    end else begin
                        e = sb.pop_front();
                        check("en_delay", dly, SETUP + 1);
                        check("pulses", pcnt, NPH);
                        check("busy_len", bcnt, BUSY_LEN);
                        check("data", int'(seen), int'(e.data));
                        check("rs", int'(rs_s), int'(e.rs));
                        check("rw", int'(rw_s), int'(e.rw));
                        check("oe", int'(oe_s), int'(e.oe));
                        check("oe_idle", int'(oe), 0);
                        check("rd_data", int'(rd), int'(e.rd));
                    end
                    act = 0;
                end
            end
            en_prev = en;
        end
    end

    task automatic wait_idle();
        bit seen_busy = 0;
        for (int i = 0; i < 2 * BUSY_LEN + 100; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1;
            else if (seen_busy) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_idle_timeout actual=%0d required=0", busy);
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic w,
                        input logic o, input logic [7:0] r);
        exp_t e;
        e.data = d; e.rs = s; e.rw = w; e.oe = o; e.rd = r;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, int'(en), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_oe"}, int'(oe), 0);
        check({tag, "_rs"}, int'(rs), 0);
        check({tag, "_rw"}, int'(rw), 0);
        check({tag, "_on"}, int'(on), 0);
        check({tag, "_data"}, int'(dout), 0);
        check({tag, "_rd"}, int'(rd), 0);
    endtask

    logic [7:0] rd_exp;
    int         bad;

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Write 0x41 with RS=1; a GO edge during WAIT must be dropped.
        push(8'h41, 1'b1, 1'b0, 1'b1, 8'h00);
        @(negedge clk) word = 32'h8000_0541;
        repeat (3) @(negedge clk);
        word = 32'h8000_0141;
        repeat (40) @(negedge clk);
        word = 32'h8000_0541;
        repeat (2) @(negedge clk);
        word = 32'h8000_0141;
        wait_idle();
        check("on_copy", int'(on), 1);

        // Read with panel returning 0x80.
`ifdef LCD_4BIT_EN
        rd_exp = 8'h88;
`else
        rd_exp = 8'h80;
`endif
        din = 8'h80;
        push(8'h00, 1'b0, 1'b1, 1'b0, rd_exp);
        @(negedge clk) word = 32'h8000_0600;
        repeat (3) @(negedge clk);
        word = 32'h8000_0200;
        wait_idle();
        din = 8'h00;

        // GO edge while ON = 0 is ignored.
        @(negedge clk) word = 32'h0000_0400;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("off_busy", bad, 0);
        word = 32'h0000_0000;
        repeat (2) @(negedge clk);

        // Back-to-back: second GO sampled one cycle after busy falls.
        push(8'h33, 1'b1, 1'b0, 1'b1, rd_exp);
        push(8'h55, 1'b0, 1'b0, 1'b1, rd_exp);
        @(negedge clk) word = 32'h8000_0533;
        repeat (3) @(negedge clk);
        word = 32'h8000_0133;
        wait_idle();
        word = 32'h8000_0455;
        @(negedge clk);
        check("b2b_restart", int'(busy), 1);
        repeat (2) @(negedge clk);
        word = 32'h8000_0055;
        wait_idle();

        // Asynchronous reset in the middle of the EN pulse.
        @(negedge clk) word = 32'h8000_05C3;
        repeat (15) @(negedge clk);
        check("pre_rst_en", int'(en), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        word = 32'h8000_0000;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Full transaction after reset; read data was cleared.
        push(8'hC3, 1'b1, 1'b0, 1'b1, 8'h00);
        @(negedge clk) word = 32'h8000_05C3;
        repeat (3) @(negedge clk);
        word = 32'h8000_01C3;
        wait_idle();

        repeat (50) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("txn_count", ntxn, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
